// File: rtl/riscv_pkg.sv
// Shared RISC-V sizing constants for the front end.
//   ALEN  : byte-address width
//   XLEN  : instruction/data word width
//   NOP_A : canonical NOP (addi x0, x0, 0), shown when no instruction is held
package riscv_pkg;
  localparam int ALEN = 32;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_A = 32'h0000_0013;
endpackage

// File: rtl/fetch_dec_if.sv
// Fetch-to-decode handshake bundle.
//   out_valid : head entry valid (fetch -> decode)
//   out_ready : decode accepts the head entry this cycle (decode -> fetch)
//   out_pc    : byte address of the head instruction
//   out_instr : head instruction word
// master = fetch side, slave = decode side.
interface fetch_dec_if;
  import riscv_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [ALEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (output out_valid, output out_pc, output out_instr, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_instr, output out_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch PC register feeding a 2-entry {pc, instr}
// FIFO toward decode. One instruction per cycle in steady state; a redirect
// flushes the FIFO and restarts fetch at the word-aligned target.
// Ports:
//   clk            : clock, all state on rising edge
//   rst            : asynchronous active-low reset
//   imem_addr      : byte address to instruction memory (== fetch_pc)
//   imem_instr     : instruction returned combinationally for imem_addr
//   redirect_valid : branch/jump redirect request (highest priority)
//   redirect_pc    : redirect target byte address
//   dec            : decode handshake (out_valid/out_ready/out_pc/out_instr)
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [ALEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ALEN-1:0]     imem_addr,
  input  logic [XLEN-1:0]     imem_instr,
  input  logic                redirect_valid,
  input  logic [ALEN-1:0]     redirect_pc,
  fetch_dec_if.master         dec
);

  logic [ALEN-1:0] fetch_pc;
  logic [1:0]      count;
  logic [ALEN-1:0] pc_e0;
  logic [ALEN-1:0] pc_e1;
  logic [XLEN-1:0] instr_e0;
  logic [XLEN-1:0] instr_e1;
  logic            head_valid;
  logic            pop;
  logic            enq;

  assign imem_addr  = fetch_pc;
  assign head_valid = (count != 2'd0);
  assign pop        = head_valid && dec.out_ready;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign enq        = !redirect_valid && ((count != 2'd2) || pop);

  // Control state: fetch PC and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
    end else if (redirect_valid) begin
      count    <= 2'd0;
      fetch_pc <= {redirect_pc[ALEN-1:2], 2'b00};
    end else begin
      if (enq) begin
        fetch_pc <= fetch_pc + ALEN'(4);
      end
      case ({enq, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage. Entries are qualified by count, so they need no reset;
  // stale contents after a pop or flush are never visible.
  always_ff @(posedge clk) begin
    if (pop) begin
      pc_e0    <= pc_e1;
      instr_e0 <= instr_e1;
    end
    if (enq) begin
      // The new entry lands at the head slot when the FIFO is, or is about
      // to become, empty; this overrides the shift above.
      if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
        pc_e0    <= fetch_pc;
        instr_e0 <= imem_instr;
      end else begin
        pc_e1    <= fetch_pc;
        instr_e1 <= imem_instr;
      end
    end
  end

  // Outputs come only from the head register, masked while empty so reset
  // clears them immediately through count.
  assign dec.out_valid = head_valid;
  assign dec.out_pc    = head_valid ? pc_e0 : '0;
  assign dec.out_instr = head_valid ? instr_e0 : NOP_A;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 0, meaning the byte address fetched first after reset (bits [1:0] SHALL be 0).
REQ-002 The block SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 The block SHALL have port imem_addr  out  ALEN  byte address driven to the instruction memory.
REQ-005 The block SHALL have port imem_instr  in  XLEN  instruction returned combinationally by the instruction memory for imem_addr in the same cycle.
REQ-006 The block SHALL have port redirect_valid  in  1  branch/jump redirect request.
REQ-007 The block SHALL have port redirect_pc  in  ALEN  redirect target byte address.
REQ-008 The block SHALL have port out_valid  out  1  head entry valid toward decode.
REQ-009 The block SHALL have port out_ready  in  1  decode accepts the head entry this cycle.
REQ-010 The block SHALL have port out_pc  out  ALEN  byte address of the head instruction.
REQ-011 The block SHALL have port out_instr  out  XLEN  head instruction word.
REQ-012 ALEN, XLEN and NOP_A SHALL be taken from riscv_pkg.

Function
REQ-013 The block SHALL hold a fetch PC register (fetch_pc) and a 2-entry FIFO of {pc, instr} pairs with an occupancy count of 0, 1 or 2.
REQ-014 imem_addr SHALL equal fetch_pc combinationally at all times.
REQ-015 pop SHALL be out_valid && out_ready; a pop SHALL remove the head entry at the clock edge.
REQ-016 enq SHALL be !redirect_valid && (count < 2 || pop); on enq, {fetch_pc, imem_instr} SHALL be written at the tail and fetch_pc SHALL advance by 4.
REQ-017 fetch_pc + 4 SHALL wrap modulo 2^ALEN with no error indication.
REQ-018 When count == 2 and pop == 1, enq SHALL occur in the same cycle and count SHALL stay 2.
REQ-019 When count == 2 and pop == 0, fetch_pc and the FIFO SHALL hold.
REQ-020 out_valid SHALL be (count != 0); out_pc/out_instr SHALL come from the head register (no combinational path from imem_instr or redirect_*).
REQ-021 When count == 0, out_pc SHALL be 0 and out_instr SHALL be NOP_A.
REQ-022 out_pc/out_instr SHALL remain stable while out_valid == 1 and out_ready == 0.
REQ-023 Redirect SHALL have priority over everything else: when redirect_valid == 1, the FIFO SHALL be flushed (count <= 0), no enq SHALL occur, and fetch_pc SHALL load {redirect_pc[ALEN-1:2], 2'b00}.
REQ-024 A pop coincident with a redirect SHALL be treated as accepted by decode; the flush still discards all remaining entries.
REQ-025 Redirect latency: redirect in cycle N, imem_addr = target in cycle N+1, target instruction at outputs with out_valid == 1 in cycle N+2.
REQ-026 Consecutive redirects SHALL each restart the latency of REQ-025; only the last target is fetched.
REQ-027 Throughput with out_ready held 1 SHALL be one instruction per cycle in steady state.

Reset
REQ-028 While rst == 0: fetch_pc = RESET_PC, count = 0, out_valid = 0, out_pc = 0, out_instr = NOP_A, imem_addr = RESET_PC.
REQ-029 Reset assertion mid-operation SHALL discard all FIFO contents immediately (asynchronously).
REQ-030 In the first cycle after rst deasserts, imem_addr = RESET_PC; the instruction at RESET_PC SHALL be at outputs with out_valid == 1 in the following cycle.

Verification
REQ-031 Reset release, RESET_PC = 0, memory word i = 0x100+i, out_ready = 1 -> out_pc 0,4,8,12 on consecutive cycles with out_instr 0x100,0x101,0x102,0x103.
REQ-032 out_ready = 0 for 5 cycles after reset -> count saturates at 2, imem_addr holds at 8, out_pc stays 0; raise out_ready -> out_pc 0,4,8 back-to-back with no bubble.
REQ-033 Redirect_pc = 0x40 in cycle N with FIFO full -> out_valid = 0 in N+1, out_pc = 0x40 valid in N+2, out_pc = 0x44 in N+3.
REQ-034 Redirect_pc = 0x43 -> fetch at 0x40, out_pc = 0x40.
REQ-035 Redirect_pc = 0xFFFF_FFFC (ALEN = 32), out_ready = 1 -> out_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-036 Assert rst low mid-stream with count = 2 -> out_valid drops to 0 without a clock edge; after release, fetch restarts at RESET_PC per REQ-030.
